// File: rtl/jtframe_arb_pkg.sv
// Shared types for the SDRAM read-port arbiter: FSM state encoding and timer width.
package jtframe_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // port free, looking for a requester
        ISSUE = 2'd1,   // sdram_req high, waiting for sdram_ack
        WAIT  = 2'd2,   // request accepted, waiting for data_rdy
        DONE  = 2'd3    // rdy pulse cycle, round-robin pointer advances
    } arb_state_t;

    // Width of the data_rdy watchdog timer
    localparam int TMR_W = 8;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker. Searches req starting at ptr and
// wrapping from NREQ-1 back to 0; returns the first asserted index.
// Build option JTFRAME_ARB_PRIO_EN: requester 0 wins whenever it is asserted,
// the rest rotate among themselves.
module jtframe_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   grant,
    output logic            valid
);

    int idx;

    // First asserted request at or after the pointer
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        valid = 1'b0;
        idx   = 0;
`ifdef JTFRAME_ARB_PRIO_EN
        if (req[0]) begin
            grant = '0;
            valid = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (int'(ptr) + i) % NREQ;
                if (!valid && idx != 0 && req[idx]) begin
                    grant = PW'(idx);
                    valid = 1'b1;
                end
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                grant = PW'(idx);
                valid = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// SDRAM read-port arbiter: shares one game-side SDRAM read port among NREQ
// ROM fetchers, one read at a time, returning data with a one-cycle rdy pulse
// to the requester that was granted. Refresh is allowed while the port idles.
// Build option JTFRAME_ARB_PRIO_EN (see jtframe_rr_pick): requester 0 gets
// fixed top priority.
module jtframe_sdram_arb
    import jtframe_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 22,
    parameter int DW   = 32,
    parameter int TOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loop_rst,
    input  logic              downloading,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]   rdy,
    output logic [DW-1:0]     dout,
    output logic              sdram_req,
    output logic [AW-1:0]     sdram_addr,
    input  logic              sdram_ack,
    input  logic              data_rdy,
    input  logic [DW-1:0]     data_read,
    output logic              refresh_en,
    output logic              tout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state, state_nx;
    logic [PW-1:0]     gnt;        // requester owning the current transaction
    logic [PW-1:0]     rr_ptr;     // where the next round-robin search starts
    logic [PW-1:0]     pick_g;
    logic              pick_v;
    logic [TMR_W-1:0]  timer;
    logic [AW-1:0]     addr_a [NREQ];

    // FSM strobes consumed by the datapath register block
    logic              take_grant;
    logic              take_data;
    logic              timeout;
    logic              clr_timer;

    // Unpack the flat address bus into one word per requester
    for (genvar i = 0; i < NREQ; i++) begin : g_addr
        assign addr_a[i] = addr[i*AW +: AW];
    end

    jtframe_rr_pick #(
        .NREQ  ( NREQ   ),
        .PW    ( PW     )
    ) u_pick (
        .req   ( req    ),
        .ptr   ( rr_ptr ),
        .grant ( pick_g ),
        .valid ( pick_v )
    );

    // The request line is high exactly while the FSM sits in ISSUE
    assign sdram_req  = (state == ISSUE);
    // Refresh may run whenever the port is free, and always during downloads
    assign refresh_en = downloading | ((state == IDLE) & ~|req);

    // Next-state logic and datapath strobes
    always_comb begin
        state_nx   = state;
        take_grant = 1'b0;
        take_data  = 1'b0;
        timeout    = 1'b0;
        clr_timer  = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading && pick_v) begin
                    take_grant = 1'b1;
                    state_nx   = ISSUE;
                end
            end
            ISSUE: begin
                if (sdram_ack) begin
                    clr_timer = 1'b1;
                    // data arriving together with the ack is taken straight away
                    if (data_rdy) begin
                        take_data = 1'b1;
                        state_nx  = DONE;
                    end else begin
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_rdy) begin
                    take_data = 1'b1;
                    state_nx  = DONE;
                end else if (timer == TMR_W'(TOUT)) begin
                    timeout   = 1'b1;
                    state_nx  = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register; loop_rst flushes exactly like rst but synchronously
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= IDLE;
        end else if (loop_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant/address latch, watchdog timer, returned data and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            rr_ptr     <= '0;
            sdram_addr <= '0;
            timer      <= '0;
            dout       <= '0;
            rdy        <= '0;
            tout_err   <= 1'b0;
        end else if (loop_rst) begin
            gnt        <= '0;
            rr_ptr     <= '0;
            sdram_addr <= '0;
            timer      <= '0;
            dout       <= '0;
            rdy        <= '0;
            tout_err   <= 1'b0;
        end else begin
            rdy <= '0;
            // address is latched once; later changes on addr wait for the next grant
            if (take_grant) begin
                gnt        <= pick_g;
                sdram_addr <= addr_a[pick_g];
            end
            if (clr_timer) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end
            // a requester that already dropped its req gets no pulse
            if (take_data) begin
                dout     <= data_read;
                rdy[gnt] <= req[gnt];
            end
            if (timeout) begin
                tout_err <= 1'b1;
            end
            if (state == DONE) begin
                rr_ptr <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed self-checking bench for jtframe_sdram_arb (default NREQ=4, AW=22, DW=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jtframe_sdram_arb;

    localparam int NREQ = 4;
    localparam int AW   = 22;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               loop_rst;
    logic               downloading;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    rdy;
    logic [DW-1:0]      dout;
    logic               sdram_req;
    logic [AW-1:0]      sdram_addr;
    logic               sdram_ack;
    logic               data_rdy;
    logic [DW-1:0]      data_read;
    logic               refresh_en;
    logic               tout_err;

    int                 n_checks = 0;
    int                 n_bad    = 0;
    logic [AW-1:0]      addr_tab [NREQ];
    int                 exp_ord  [8];

    always #5 clk = ~clk;

    jtframe_sdram_arb #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TOUT(255)
    ) dut (
        .clk         ( clk         ),
        .rst         ( rst         ),
        .loop_rst    ( loop_rst    ),
        .downloading ( downloading ),
        .req         ( req         ),
        .addr        ( addr        ),
        .rdy         ( rdy         ),
        .dout        ( dout        ),
        .sdram_req   ( sdram_req   ),
        .sdram_addr  ( sdram_addr  ),
        .sdram_ack   ( sdram_ack   ),
        .data_rdy    ( data_rdy    ),
        .data_read   ( data_read   ),
        .refresh_en  ( refresh_en  ),
        .tout_err    ( tout_err    )
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Wait a bounded number of falling edges for sdram_req
    task automatic wait_req(input string tag, input int maxc);
        int t;
        t = 0;
        while (!sdram_req && t < maxc) begin
            @(negedge clk);
            t++;
        end
        check(tag, sdram_req, 1);
    endtask

    // Hold off n cycles, then acknowledge for one cycle
    task automatic do_ack(input int n);
        repeat (n) @(negedge clk);
        check("req_until_ack", sdram_req, 1);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        check("req_after_ack", sdram_req, 0);
    endtask

    // Hold off n cycles, then return data for one cycle; returns on the DONE cycle
    task automatic do_data(input int n, input logic [DW-1:0] d);
        repeat (n) @(negedge clk);
        data_read = d;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; loop_rst = 1'b0; downloading = 1'b0; req = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        addr_tab[0] = 22'h3F000;
        addr_tab[1] = 22'h00ABC;
        addr_tab[2] = 22'h01234;
        addr_tab[3] = 22'h2AAAA;
        for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = addr_tab[i];
`ifdef JTFRAME_ARB_PRIO_EN
        for (int i = 0; i < 8; i++) exp_ord[i] = 0;
`else
        for (int i = 0; i < 8; i++) exp_ord[i] = i % NREQ;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_rdy",        rdy,        0);
        check("rst_dout",       dout,       0);
        check("rst_sdram_req",  sdram_req,  0);
        check("rst_sdram_addr", sdram_addr, 0);
        check("rst_refresh",    refresh_en, 1);
        check("rst_tout_err",   tout_err,   0);

        // All four requesting continuously: rotation order
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_req("ord_req", 4);
            check("ord_addr", sdram_addr, addr_tab[exp_ord[k]]);
            do_ack(1);
            do_data(2, 32'h1000_0000 + k);
            check("ord_rdy",  rdy,  onehot(exp_ord[k]));
            check("ord_dout", dout, 32'h1000_0000 + k);
        end
        req = '0;
        @(negedge clk);

        // Single requester 2: latency, latched address, one-cycle rdy
        req = 4'b0100;
        @(negedge clk);
        check("lat_sdram_req", sdram_req, 1);
        check("t1_addr", sdram_addr, 22'h01234);
        do_ack(3);
        do_data(5, 32'hCAFEBABE);
        check("t1_rdy",  rdy,  4'b0100);
        check("t1_dout", dout, 32'hCAFEBABE);
        req = '0;
        @(negedge clk);
        check("t1_rdy_off",  rdy,        0);
        check("t1_idle_ref", refresh_en, 1);

        // Downloading blocks grants; served once it falls
        downloading = 1'b1;
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("dl_no_req",  sdram_req,  0);
            check("dl_refresh", refresh_en, 1);
        end
        downloading = 1'b0;
        wait_req("dl_grant", 2);
        check("dl_addr", sdram_addr, 22'h00ABC);
        do_ack(0);
        do_data(1, 32'h5A5A0001);
        check("dl_rdy", rdy, 4'b0010);
        req = '0;
        @(negedge clk);

        // ack and data_rdy together in ISSUE
        req = 4'b1000;
        wait_req("both_req", 4);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h0BADF00D;
        @(negedge clk);
        sdram_ack = 1'b0; data_rdy = 1'b0;
        check("both_rdy",  rdy,  4'b1000);
        check("both_dout", dout, 32'h0BADF00D);
        req = '0;
        @(negedge clk);

        // Requester 3 drops during WAIT: no rdy pulse, back to IDLE
        req = 4'b1000;
        wait_req("drop_req", 4);
        do_ack(0);
        req = '0;
        do_data(2, 32'hDEAD0003);
        check("drop_rdy", rdy, 0);
        @(negedge clk);
        check("drop_idle", refresh_en, 1);

        // Stray data_rdy in IDLE is ignored
        data_read = 32'h11111111; data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        @(negedge clk);
        check("stray_rdy",  rdy,  0);
        check("stray_dout", dout, 32'hDEAD0003);

        // Timeout: no data_rdy after ack
        req = 4'b0001;
        wait_req("to_req", 4);
        do_ack(0);
        repeat (250) @(negedge clk);
        check("to_early", tout_err, 0);
        for (int t = 0; t < 20 && !tout_err; t++) @(negedge clk);
        check("to_err", tout_err, 1);
        check("to_idle_req", sdram_req, 0);
        wait_req("to_next_req", 4);
        check("to_next_addr", sdram_addr, 22'h3F000);
        do_ack(1);
        do_data(1, 32'h600D600D);
        check("to_next_rdy",  rdy,  4'b0001);
        check("to_next_dout", dout, 32'h600D600D);
        req = '0;
        @(negedge clk);
        check("to_sticky", tout_err, 1);

        // loop_rst during WAIT, then a late data_rdy
        req = 4'b0010;
        wait_req("lr_req", 4);
        do_ack(0);
        @(negedge clk);
        loop_rst = 1'b1;
        req = '0;
        @(negedge clk);
        loop_rst = 1'b0;
        check("lr_rdy",        rdy,        0);
        check("lr_dout",       dout,       0);
        check("lr_sdram_req",  sdram_req,  0);
        check("lr_sdram_addr", sdram_addr, 0);
        check("lr_refresh",    refresh_en, 1);
        check("lr_tout_err",   tout_err,   0);
        data_read = 32'hFFFF0000; data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        @(negedge clk);
        check("lr_late_rdy",  rdy,  0);
        check("lr_late_dout", dout, 0);

        // Move the pointer to 2, then async rst in WAIT must bring it back to 0
        req = 4'b0010;
        wait_req("ar_pre_req", 4);
        do_ack(0);
        do_data(0, 32'h00000042);
        check("ar_pre_rdy", rdy, 4'b0010);
        req = 4'b0100;
        wait_req("ar_req", 4);
        do_ack(0);
        #2 rst = 1'b1;
        #1;
        check("ar_sdram_req",  sdram_req,  0);
        check("ar_sdram_addr", sdram_addr, 0);
        check("ar_dout",       dout,       0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        data_read = 32'h77777777; data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        check("ar_late_rdy", rdy, 0);
        req = 4'b1111;
        wait_req("ar_ptr_req", 4);
        check("ar_ptr_addr", sdram_addr, 22'h3F000);
        do_ack(0);
        do_data(0, 32'h12345678);
        check("ar_ptr_rdy", rdy, 4'b0001);
        req = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
